writeback_arbiter: RTL and testbench

- Writeback stage directly upstream of the register file; drives the regfile's single write port (o_rd_addr/o_rd_data feed the regfile's i_rd_addr/i_rd_data).
- Merges two result sources:
  - the in-order main pipeline (ALU/load results), with load byte/halfword extraction;
  - the long-latency mul/div unit, through a 1-entry holding buffer.
- Keeps a pending-destination scoreboard so decode can stall on operands still owed by mul/div.
- Prevents mul/div starvation by stalling the pipeline for one cycle.

---
 rtl/writeback_arbiter.sv | 160 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter
// -----------------
// Writeback stage in front of the register file's single write port. It
// merges the in-order pipeline results with the long-latency mul/div results.
//
// Pipeline results are written in the cycle they arrive. Loads get their byte
// or halfword extracted here.
//
// Mul/div results pass through a 1-entry holding buffer. The buffer drains
// whenever the pipeline is not writing. If it is blocked for STARVE_LIMIT
// cycles, the pipeline is stalled for one cycle and the buffer drains.
//
// A pending-destination scoreboard tells decode which source registers are
// still owed a result by mul/div.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pipe_*              pipeline result (valid, rd, data, load info)
//   o_pipe_stall          pipeline must hold its writeback result
//   i_md_issue(_rd)       mul/div op issued, with its destination
//   i_md_valid/o_md_ready mul/div result handshake
//   i_md_rd_addr/i_md_data
//                         mul/div result destination and data
//   o_rd_addr/o_rd_data   regfile write port (address 0 = no write)
//   i_rsX_addr/o_rsX_busy decode operand scoreboard lookup
`timescale 1ns/1ps

module writeback_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pipe_valid,
  input  logic [4:0]  i_pipe_rd_addr,
  input  logic [31:0] i_pipe_data,
  input  logic        i_pipe_is_load,
  input  logic [2:0]  i_pipe_funct3,
  input  logic [1:0]  i_pipe_addr_lo,
  output logic        o_pipe_stall,
  input  logic        i_md_issue,
  input  logic [4:0]  i_md_issue_rd,
  input  logic        i_md_valid,
  output logic        o_md_ready,
  input  logic [4:0]  i_md_rd_addr,
  input  logic [31:0] i_md_data,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic        r_buf_valid;
  logic [4:0]  r_buf_rd;
  logic [31:0] r_buf_data;
  logic [3:0]  r_starve_cnt;
  logic        r_force_md;
  logic [31:0] r_pending;

  logic        w_pipe_wr;
  logic        w_drain;
  logic        w_md_ready;
  logic        w_md_accept;
  logic [31:0] w_pipe_data_x;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_starve_next;
  logic [31:0] w_pending_next;

  // Write-port arbitration. Every output is forced idle while reset is held.
  // A forced-drain cycle masks the pipeline write so that the buffer wins.
  always_comb begin
    w_pipe_wr   = !i_rst && i_pipe_valid && (i_pipe_rd_addr != 5'd0) && !r_force_md;
    w_drain     = !i_rst && !w_pipe_wr && r_buf_valid;
    w_md_ready  = !i_rst && (!r_buf_valid || w_drain);
    w_md_accept = i_md_valid && w_md_ready;
  end

  // Load extraction: select the byte lane by addr_lo[1:0].
  // Select the halfword by addr_lo[1].
  always_comb begin
    w_byte = 8'(i_pipe_data >> {i_pipe_addr_lo, 3'b000});
    w_half = i_pipe_addr_lo[1] ? i_pipe_data[31:16] : i_pipe_data[15:0];
    w_pipe_data_x = i_pipe_data;
    if (i_pipe_is_load) begin
      case (i_pipe_funct3)
        3'b000:  w_pipe_data_x = {{24{w_byte[7]}}, w_byte};
        3'b100:  w_pipe_data_x = {24'd0, w_byte};
        3'b001:  w_pipe_data_x = {{16{w_half[15]}}, w_half};
        3'b101:  w_pipe_data_x = {16'd0, w_half};
        default: w_pipe_data_x = i_pipe_data;
      endcase
    end
  end

  always_comb begin
    o_rd_addr = 5'd0;
    o_rd_data = 32'd0;
    if (w_pipe_wr) begin
      o_rd_addr = i_pipe_rd_addr;
      o_rd_data = w_pipe_data_x;
    end else if (w_drain) begin
      o_rd_addr = r_buf_rd;
      o_rd_data = r_buf_data;
    end
  end

  assign o_md_ready   = w_md_ready;
  assign o_pipe_stall = !i_rst && r_force_md;
  assign o_rs1_busy   = !i_rst && r_pending[i_rs1_addr] && (i_rs1_addr != 5'd0);
  assign o_rs2_busy   = !i_rst && r_pending[i_rs2_addr] && (i_rs2_addr != 5'd0);

  // Starvation counter. It counts cycles in which a held result is blocked,
  // saturates at 15, and clears on drain or when the buffer is empty.
  always_comb begin
    w_starve_next = 4'd0;
    if (r_buf_valid && !w_drain)
      w_starve_next = (r_starve_cnt == 4'hF) ? r_starve_cnt : r_starve_cnt + 4'd1;
  end

  // The scoreboard clears on drain. An issue to the same register in the
  // same cycle is applied last, so the set wins.
  always_comb begin
    w_pending_next = r_pending;
    if (w_drain)
      w_pending_next[r_buf_rd] = 1'b0;
    if (i_md_issue && (i_md_issue_rd != 5'd0))
      w_pending_next[i_md_issue_rd] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf_valid  <= 1'b0;
      r_buf_rd     <= 5'd0;
      r_buf_data   <= 32'd0;
      r_starve_cnt <= 4'd0;
      r_force_md   <= 1'b0;
      r_pending    <= 32'd0;
    end else begin
      r_starve_cnt <= w_starve_next;
      // Force is raised in the cycle after the counter reaches the limit.
      // The forced cycle always drains, so the counter returns to 0 and the
      // flag lasts for exactly one cycle.
      r_force_md   <= (w_starve_next == LIMIT);
      r_pending    <= w_pending_next;
      if (w_md_accept) begin
        // A result for x0 is accepted but dropped.
        r_buf_valid <= (i_md_rd_addr != 5'd0);
        r_buf_rd    <= i_md_rd_addr;
        r_buf_data  <= i_md_data;
      end else if (w_drain) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
`timescale 1ns/1ps

module tb_writeback_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_is_load;
  logic [2:0]  pipe_funct3;
  logic [1:0]  pipe_addr_lo;
  logic        pipe_stall;
  logic        md_issue;
  logic [4:0]  md_issue_rd;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        rs1_busy;
  logic        rs2_busy;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  writeback_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_pipe_valid  (pipe_valid),
    .i_pipe_rd_addr(pipe_rd),
    .i_pipe_data   (pipe_data),
    .i_pipe_is_load(pipe_is_load),
    .i_pipe_funct3 (pipe_funct3),
    .i_pipe_addr_lo(pipe_addr_lo),
    .o_pipe_stall  (pipe_stall),
    .i_md_issue    (md_issue),
    .i_md_issue_rd (md_issue_rd),
    .i_md_valid    (md_valid),
    .o_md_ready    (md_ready),
    .i_md_rd_addr  (md_rd),
    .i_md_data     (md_data),
    .o_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .i_rs1_addr    (rs1_addr),
    .i_rs2_addr    (rs2_addr),
    .o_rs1_busy    (rs1_busy),
    .o_rs2_busy    (rs2_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Move to the falling edge. Every regfile write seen there is checked
  // against the oldest expected write in the queue.
  task automatic sample();
    wr_t e;
    @(negedge clk);
    if (rd_addr !== 5'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {27'd0, rd_addr}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {27'd0, rd_addr}, {27'd0, e.addr});
        check("wr_data", rd_data, e.data);
      end
    end
    $display("t=%0t rst=%0b pipe_v=%0b rd=%0d stall=%0b md_v=%0b md_rdy=%0b wr_addr=%0d wr_data=%h busy=%0b%0b",
             $time, rst, pipe_valid, pipe_rd, pipe_stall, md_valid, md_ready,
             rd_addr, rd_data, rs1_busy, rs2_busy);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] rd, input logic [31:0] d,
                      input logic ld, input logic [2:0] f3, input logic [1:0] lo);
    pipe_valid   = v;
    pipe_rd      = rd;
    pipe_data    = d;
    pipe_is_load = ld;
    pipe_funct3  = f3;
    pipe_addr_lo = lo;
  endtask

  initial begin
    rst = 1'b1;
    pipe(1'b1, 5'd5, 32'h1234, 1'b0, 3'd0, 2'd0);
    md_issue = 1'b0; md_issue_rd = 5'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;

    // Outputs are idle while reset is held, even with a pipeline result present.
    sample();
    check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    check("rst_md_ready", {31'd0, md_ready}, 32'd0);
    check("rst_stall", {31'd0, pipe_stall}, 32'd0);
    edge_step();
    sample();
    edge_step();
    rst = 1'b0;

    // The ALU result is written in the same cycle.
    push(5'd5, 32'h1234);
    sample();
    check("alu_stall", {31'd0, pipe_stall}, 32'd0);
    check("idle_md_ready", {31'd0, md_ready}, 32'd1);
    edge_step();

    // Load extraction cases.
    pipe(1'b1, 5'd6, 32'h80FF7F01, 1'b1, 3'b000, 2'd3); push(5'd6, 32'hFFFFFF80); sample(); edge_step();
    pipe(1'b1, 5'd6, 32'h80FF7F01, 1'b1, 3'b101, 2'd2); push(5'd6, 32'h000080FF); sample(); edge_step();
    pipe(1'b1, 5'd6, 32'h80FF7F01, 1'b1, 3'b001, 2'd0); push(5'd6, 32'h00007F01); sample(); edge_step();
    pipe(1'b1, 5'd6, 32'h80FF7F01, 1'b1, 3'b100, 2'd2); push(5'd6, 32'h000000FF); sample(); edge_step();
    pipe(1'b1, 5'd6, 32'h80FF7F01, 1'b1, 3'b001, 2'd2); push(5'd6, 32'hFFFF80FF); sample(); edge_step();
    pipe(1'b1, 5'd6, 32'h80FF7F01, 1'b1, 3'b010, 2'd1); push(5'd6, 32'h80FF7F01); sample(); edge_step();
    pipe(1'b1, 5'd6, 32'h80FF7F01, 1'b0, 3'b000, 2'd3); push(5'd6, 32'h80FF7F01); sample(); edge_step();

    // Issue to x7. It is busy from the next cycle until the cycle after the drain.
    pipe(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
    md_issue = 1'b1; md_issue_rd = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd0;
    sample();
    check("busy_same_cycle", {31'd0, rs1_busy}, 32'd0);
    edge_step();
    md_issue = 1'b0;
    sample();
    check("rs1_busy_after_issue", {31'd0, rs1_busy}, 32'd1);
    check("rs2_x0_not_busy", {31'd0, rs2_busy}, 32'd0);
    edge_step();
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'hDEAD;
    sample();
    check("md_accept_ready", {31'd0, md_ready}, 32'd1);
    edge_step();
    md_valid = 1'b0;
    push(5'd7, 32'hDEAD);
    sample();
    check("busy_during_drain", {31'd0, rs1_busy}, 32'd1);
    edge_step();
    sample();
    check("busy_cleared", {31'd0, rs1_busy}, 32'd0);
    edge_step();

    // Hold x9 behind continuous pipeline writes. After four blocked cycles it is forced out.
    pipe(1'b1, 5'd10, 32'h100, 1'b0, 3'd0, 2'd0);
    md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
    push(5'd10, 32'h100);
    sample();
    check("starve_accept", {31'd0, md_ready}, 32'd1);
    edge_step();
    md_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pipe_data = 32'h100 + 32'(i);
      push(5'd10, 32'h100 + 32'(i));
      sample();
      check("held_md_ready", {31'd0, md_ready}, 32'd0);
      check("held_no_stall", {31'd0, pipe_stall}, 32'd0);
      edge_step();
    end
    pipe_data = 32'h105;
    push(5'd9, 32'h99);
    sample();
    check("force_stall", {31'd0, pipe_stall}, 32'd1);
    check("force_md_ready", {31'd0, md_ready}, 32'd1);
    edge_step();
    push(5'd10, 32'h105);
    sample();
    check("resume_stall", {31'd0, pipe_stall}, 32'd0);
    edge_step();

    // Set x3 pending, then drain x3 and issue x3 in the same cycle: the set wins.
    // A back-to-back result for x11 is accepted in the drain cycle.
    pipe(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
    md_issue = 1'b1; md_issue_rd = 5'd3;
    sample(); edge_step();
    md_issue = 1'b0;
    md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h333;
    sample(); edge_step();
    md_issue = 1'b1; md_issue_rd = 5'd3;
    md_valid = 1'b1; md_rd = 5'd11; md_data = 32'hBBB;
    push(5'd3, 32'h333);
    sample();
    check("b2b_md_ready", {31'd0, md_ready}, 32'd1);
    edge_step();
    md_issue = 1'b0; md_valid = 1'b0;
    rs1_addr = 5'd3;
    // A pipeline result for x0 does not block the drain.
    pipe(1'b1, 5'd0, 32'hFFFF, 1'b0, 3'd0, 2'd0);
    push(5'd11, 32'hBBB);
    sample();
    check("set_wins_busy", {31'd0, rs1_busy}, 32'd1);
    edge_step();

    // A result for x0 is accepted and dropped.
    pipe(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
    md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h5A5A;
    sample(); edge_step();
    md_valid = 1'b0;
    sample();
    check("x0_dropped_no_write", {27'd0, rd_addr}, 32'd0);
    check("x0_dropped_ready", {31'd0, md_ready}, 32'd1);
    edge_step();

    // Reset while a result is held and registers are pending.
    md_issue = 1'b1; md_issue_rd = 5'd12;
    pipe(1'b1, 5'd13, 32'hA1, 1'b0, 3'd0, 2'd0);
    push(5'd13, 32'hA1);
    sample(); edge_step();
    md_issue = 1'b0;
    md_valid = 1'b1; md_rd = 5'd12; md_data = 32'hC12;
    push(5'd13, 32'hA2); pipe_data = 32'hA2;
    sample(); edge_step();
    md_valid = 1'b0;
    push(5'd13, 32'hA3); pipe_data = 32'hA3;
    rs1_addr = 5'd12; rs2_addr = 5'd3;
    sample();
    check("pre_rst_held", {31'd0, md_ready}, 32'd0);
    check("pre_rst_busy", {31'd0, rs1_busy}, 32'd1);
    edge_step();
    pipe(1'b0, 5'd0, 32'd0, 1'b0, 3'd0, 2'd0);
    rst = 1'b1;
    sample();
    check("mid_rst_md_ready", {31'd0, md_ready}, 32'd0);
    edge_step();
    rst = 1'b0;
    sample();
    check("post_rst_no_write", {27'd0, rd_addr}, 32'd0);
    check("post_rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    check("post_rst_rs2_busy", {31'd0, rs2_busy}, 32'd0);
    check("post_rst_md_ready", {31'd0, md_ready}, 32'd1);
    edge_step();
    sample();
    check("post_rst_still_idle", {27'd0, rd_addr}, 32'd0);
    edge_step();

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
